sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//   Parametrised single-clock FIFO; next generation of the 32-bit sync FIFO.
//   Configurable width/depth, occupancy count, programmable almost-full/almost-empty
//   thresholds, synchronous flush, sticky overflow/underflow error flags.
//   Sits between a producer and a consumer in the same clock domain; registered read data.
// PARAMETERS
//   WIDTH      32  data word width in bits (>=1)
//   DEPTH      8   number of entries (>=2, need not be a power of 2)
//   AF_THRESH  6   almost_full asserted when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  1   almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//   clock         in   1            rising-edge clock
//   reset         in   1            synchronous, active-low reset
//   wn            in   1            write request
//   rn            in   1            read request
//   flush         in   1            synchronous clear of contents (reset stays high)
//   clr_err       in   1            clears sticky overflow/underflow
//   DATAIN        in   WIDTH        write data, sampled at posedge when write accepted
//   DATAOUT       out  WIDTH        read data, registered
//   full          out  1            count == DEPTH
//   empty         out  1            count == 0
//   almost_full   out  1            count >= AF_THRESH
//   almost_empty  out  1            count <= AE_THRESH
//   count         out  CW           occupancy, CW = $clog2(DEPTH+1)
//   overflow      out  1            sticky: write attempted while full and no read accepted
//   underflow     out  1            sticky: read attempted while empty
// BEHAVIOUR
//   - All state changes on posedge clock. Priority: reset (low) > flush > wn/rn.
//   - Reset: wptr=rptr=0, count=0, DATAOUT=0, empty=1, full=0, almost_empty=1,
//     almost_full=0, overflow=0, underflow=0. Memory array not reset.
//   - Read accepted (rd_ok) = rn & !empty. On rd_ok: DATAOUT <= mem[rptr], rptr advances.
//     Latency 1: word visible on DATAOUT after the accepting edge. No rd_ok: DATAOUT holds.
//   - Write accepted (wr_ok) = wn & (!full | rd_ok). On wr_ok: mem[wptr] <= DATAIN, wptr advances.
//   - Pointers wrap DEPTH-1 -> 0 (explicit compare, not modulo 2^n).
//   - count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
//   - Full + wn + rn: both accepted, count stays DEPTH, full stays 1.
//   - Empty + wn + rn: write accepted, read rejected, underflow set, count becomes 1,
//     DATAOUT holds (no write-through bypass).
//   - Flags full/empty/almost_* are registered and reflect count after the same edge.
//   - overflow set on wn & full & !rd_ok (data dropped); underflow set on rn & empty.
//     Both sticky until clr_err; an error in the same cycle as clr_err wins (flag stays 1).
//   - flush: wptr=rptr=0, count=0, flags as at reset; DATAOUT, overflow, underflow unchanged;
//     wn/rn in the flush cycle ignored and raise no errors.
//   - reset mid-operation: all queued data discarded; state as listed above next cycle.
// TESTING
//   1. Reset low 1 cycle -> empty=1, full=0, count=0, DATAOUT=0, almost_empty=1, errors=0.
//   2. Write 100,150 then read twice -> DATAOUT=100 after 1st read edge, 150 after 2nd;
//      then empty=1, count=0, underflow=0.
//   3. Write 8 words 1..8 -> almost_full=1 at count=6, full=1 at count=8; 9th write (99)
//      -> overflow=1, count=8; read 8 -> DATAOUT 1..8 in order, 99 never appears.
//   4. Full, wn=rn=1 with DATAIN=42 -> DATAOUT=1, count=8, full=1; 42 read out last
//      (exercises pointer wrap). Empty, wn=rn=1 -> underflow=1, count=1.
//   5. 3 words queued, flush=1 -> count=0, empty=1, DATAOUT unchanged; next write 7 then read
//      -> DATAOUT=7. clr_err=1 with no error -> overflow=underflow=0.
//   6. Params WIDTH=8, DEPTH=5: 12 write/read pairs with pointer wrap -> data 0..11 in order,
//      count never exceeds 5, no error flags.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, threshold flags,
// synchronous flush and sticky overflow/underflow errors; read data is registered.
module sync_fifo_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wn,
  input  logic             rn,
  input  logic             flush,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] DATAIN,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr, wptr_n, rptr_n;
  logic [CW-1:0] cnt_n;
  logic rd_ok, wr_ok;
  // a write into a full FIFO is still accepted when a read frees a slot in the same cycle
  always_comb begin
    rd_ok = rn & ~empty;
    wr_ok = wn & (~full | rd_ok);
    wptr_n = (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
    rptr_n = (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
    cnt_n = (wr_ok & ~rd_ok) ? count + CW'(1) : (rd_ok & ~wr_ok) ? count - CW'(1) : count;
  end
  always_ff @(posedge clock)
    if (reset && !flush && wr_ok) mem[wptr] <= DATAIN;
  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      DATAOUT <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      almost_empty <= 1'b1;
      almost_full <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      almost_empty <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr_n;
      if (rd_ok) begin
        rptr <= rptr_n;
        DATAOUT <= mem[rptr];
      end
      count <= cnt_n;
      empty <= cnt_n == '0;
      full <= cnt_n == CW'(DEPTH);
      almost_full <= cnt_n >= CW'(AF_THRESH);
      almost_empty <= cnt_n <= CW'(AE_THRESH);
      overflow <= (wn & full & ~rd_ok) | (overflow & ~clr_err);
      underflow <= (rn & empty) | (underflow & ~clr_err);
    end
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: vector table, hand sequences and random traffic against a queue model.
module tb_sync_fifo_param;
  logic clock = 0;
  logic reset, wn, rn, flush, clr_err;
  logic [31:0] din, dout;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  logic wn2, rn2;
  logic [7:0] din2, dout2;
  logic full2, empty2, af2, ae2, ovf2, unf2;
  logic [2:0] count2;
  logic zero = 1'b0;
  int total = 0, bad = 0;
  int q[$];
  logic [31:0] m_dout = 0;
  logic m_ovf = 0, m_unf = 0;

  always #5 clock = ~clock;

  sync_fifo_param dut (
    .clock(clock), .reset(reset), .wn(wn), .rn(rn), .flush(flush), .clr_err(clr_err),
    .DATAIN(din), .DATAOUT(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) dut2 (
    .clock(clock), .reset(reset), .wn(wn2), .rn(rn2), .flush(zero), .clr_err(zero),
    .DATAIN(din2), .DATAOUT(dout2), .full(full2), .empty(empty2), .almost_full(af2),
    .almost_empty(ae2), .count(count2), .overflow(ovf2), .underflow(unf2)
  );

  typedef struct {
    logic rs, w, r, f, c;
    logic [31:0] d;
    logic [3:0] cnt;
    logic [31:0] dout;
    logic [5:0] fl;
  } vec_t;
  vec_t tv[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: update the queue model from the FIFO rules, apply, then compare.
  task automatic cycle(input logic rs, w, r, f, c, input logic [31:0] d);
    bit mfull, mempty, rd, wr;
    reset = rs; wn = w; rn = r; flush = f; clr_err = c; din = d;
    if (!rs) begin
      q.delete(); m_dout = 0; m_ovf = 0; m_unf = 0;
    end else if (f) q.delete();
    else begin
      mfull = q.size() == 8;
      mempty = q.size() == 0;
      rd = r && !mempty;
      wr = w && (!mfull || rd);
      m_ovf = (w && mfull && !rd) || (m_ovf && !c);
      m_unf = (r && mempty) || (m_unf && !c);
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(d);
    end
    @(posedge clock); #1;
    chk("model_count", 32'(count), q.size());
    chk("model_dout", dout, m_dout);
    chk("model_flags", {full, empty, almost_full, almost_empty, overflow, underflow},
        {q.size() == 8, q.size() == 0, q.size() >= 6, q.size() <= 1, m_ovf, m_unf});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held;
    int n2, exp_nxt;
    bit rd_acc, wr_acc;
    wn2 = 0; rn2 = 0; din2 = 0;
    // rs w r f c d | count dout {full,empty,af,ae,ovf,unf}
    tv[0]  = '{0, 0, 0, 0, 0, 0,   0, 0,   6'b010100};
    tv[1]  = '{1, 1, 0, 0, 0, 100, 1, 0,   6'b000100};
    tv[2]  = '{1, 1, 0, 0, 0, 150, 2, 0,   6'b000000};
    tv[3]  = '{1, 0, 1, 0, 0, 0,   1, 100, 6'b000100};
    tv[4]  = '{1, 0, 1, 0, 0, 0,   0, 150, 6'b010100};
    tv[5]  = '{1, 1, 0, 0, 0, 1,   1, 150, 6'b000100};
    tv[6]  = '{1, 1, 0, 0, 0, 2,   2, 150, 6'b000000};
    tv[7]  = '{1, 1, 0, 0, 0, 3,   3, 150, 6'b000000};
    tv[8]  = '{1, 1, 0, 0, 0, 4,   4, 150, 6'b000000};
    tv[9]  = '{1, 1, 0, 0, 0, 5,   5, 150, 6'b000000};
    tv[10] = '{1, 1, 0, 0, 0, 6,   6, 150, 6'b001000};
    tv[11] = '{1, 1, 0, 0, 0, 7,   7, 150, 6'b001000};
    tv[12] = '{1, 1, 0, 0, 0, 8,   8, 150, 6'b101000};
    tv[13] = '{1, 1, 0, 0, 0, 99,  8, 150, 6'b101010};
    tv[14] = '{1, 0, 1, 0, 0, 0,   7, 1,   6'b001010};
    tv[15] = '{1, 0, 1, 0, 0, 0,   6, 2,   6'b001010};
    tv[16] = '{1, 0, 1, 0, 0, 0,   5, 3,   6'b000010};
    tv[17] = '{1, 0, 1, 0, 0, 0,   4, 4,   6'b000010};
    tv[18] = '{1, 0, 1, 0, 0, 0,   3, 5,   6'b000010};
    tv[19] = '{1, 0, 1, 0, 0, 0,   2, 6,   6'b000010};
    tv[20] = '{1, 0, 1, 0, 0, 0,   1, 7,   6'b000110};
    tv[21] = '{1, 0, 1, 0, 0, 0,   0, 8,   6'b010110};
    tv[22] = '{1, 0, 0, 0, 1, 0,   0, 8,   6'b010100};
    for (int i = 0; i < 23; i++) begin
      cycle(tv[i].rs, tv[i].w, tv[i].r, tv[i].f, tv[i].c, tv[i].d);
      chk($sformatf("tv%0d_count", i), 32'(count), 32'(tv[i].cnt));
      chk($sformatf("tv%0d_dout", i), dout, tv[i].dout);
      chk($sformatf("tv%0d_flags", i), 32'({full, empty, almost_full, almost_empty, overflow, underflow}), 32'(tv[i].fl));
    end
    // full with simultaneous read and write, pointers wrap
    for (int i = 1; i <= 8; i++) cycle(1, 1, 0, 0, 0, i);
    cycle(1, 1, 1, 0, 0, 42);
    chk("full_rw_dout", dout, 1);
    chk("full_rw_count", 32'(count), 8);
    chk("full_rw_full", 32'(full), 1);
    for (int i = 2; i <= 8; i++) begin
      cycle(1, 0, 1, 0, 0, 0);
      chk("wrap_dout", dout, i);
    end
    cycle(1, 0, 1, 0, 0, 0);
    chk("wrap_last_42", dout, 42);
    // empty with simultaneous read and write: no bypass
    cycle(1, 1, 1, 0, 0, 5);
    chk("empty_rw_unf", 32'(underflow), 1);
    chk("empty_rw_count", 32'(count), 1);
    chk("empty_rw_dout_hold", dout, 42);
    cycle(1, 0, 1, 0, 0, 0);
    chk("empty_rw_readback", dout, 5);
    cycle(1, 0, 0, 0, 1, 0);
    // flush ignores wn/rn and raises no errors
    for (int i = 11; i <= 13; i++) cycle(1, 1, 0, 0, 0, i);
    held = dout;
    cycle(1, 1, 1, 1, 0, 77);
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_dout", dout, held);
    chk("flush_errs", 32'({overflow, underflow}), 0);
    cycle(1, 1, 0, 0, 0, 7);
    cycle(1, 0, 1, 0, 0, 0);
    chk("post_flush_dout", dout, 7);
    cycle(1, 0, 0, 0, 1, 0);
    chk("clr_noerr", 32'({overflow, underflow}), 0);
    // reset mid-operation
    cycle(1, 1, 0, 0, 0, 21);
    cycle(1, 1, 0, 0, 0, 22);
    cycle(0, 1, 1, 0, 0, 23);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_dout", dout, 0);
    // random traffic, write-heavy then read-heavy
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = (i < 300) ? 70 : 35;
      cycle($urandom_range(99) != 0, $urandom_range(99) < wp, $urandom_range(99) < 105 - wp,
            $urandom_range(49) == 0, $urandom_range(19) == 0, $urandom);
    end
    // narrow, non-power-of-2 instance: fill, stream while full, drain
    cycle(0, 0, 0, 0, 0, 0);
    reset = 1; wn = 0; rn = 0;
    n2 = 0; exp_nxt = 0;
    for (int i = 0; i < 17; i++) begin
      wn2 = i < 12; rn2 = i >= 5; din2 = 8'(i);
      rd_acc = rn2 && n2 > 0;
      wr_acc = wn2 && (n2 < 5 || rd_acc);
      n2 = n2 + int'(wr_acc) - int'(rd_acc);
      @(posedge clock); #1;
      if (rd_acc) begin
        chk("p5_dout", 32'(dout2), exp_nxt);
        exp_nxt++;
      end
      chk("p5_count", 32'(count2), n2);
      chk("p5_count_max", 32'(count2 <= 5), 1);
      chk("p5_flags", 32'({full2, empty2, ovf2, unf2}), 32'({n2 == 5, n2 == 0, 2'b00}));
    end
    chk("p5_words_read", exp_nxt, 12);
    wn2 = 0; rn2 = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
